// File: rtl/rv32_gpio_if.sv
// rv32_gpio register bus: select/strobe/mask/address/data in,
// registered read data back out.
interface rv32_gpio_if;
  logic        sel_in;
  logic        read_en_in;
  logic [3:0]  write_mask_in;
  logic [31:0] address_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;

  modport master (
    output sel_in,
    output read_en_in,
    output write_mask_in,
    output address_in,
    output write_value_in,
    input  read_value_out
  );

  modport slave (
    input  sel_in,
    input  read_en_in,
    input  write_mask_in,
    input  address_in,
    input  write_value_in,
    output read_value_out
  );
endinterface

// File: rtl/rv32_gpio.sv
// GPIO block: OUT/OE/IN/IRQ_STATUS registers, synchronised inputs.
// Edge interrupts are built only when RV32_GPIO_IRQ_EN is defined.
module rv32_gpio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  rv32_gpio_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe_out,
  output logic             irq_out
);

  logic [31:0]      lane_m;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] wdat;
  logic [1:0]       addr;
  logic             wr;
  logic             rd;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] stat_w;
  logic [31:0]      rmux;
  logic [31:0]      rdata_q;

  assign lane_m = {{8{bus.write_mask_in[3]}},
                   {8{bus.write_mask_in[2]}},
                   {8{bus.write_mask_in[1]}},
                   {8{bus.write_mask_in[0]}}};
  assign wbits  = lane_m[WIDTH-1:0];
  assign wdat   = bus.write_value_in[WIDTH-1:0];
  assign addr   = bus.address_in[3:2];
  assign wr     = bus.sel_in && (bus.write_mask_in != 4'b0);
  assign rd     = bus.sel_in && bus.read_en_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      oe_q  <= '0;
    end else if (wr) begin
      if (addr == 2'd0)
        out_q <= (out_q & ~wbits) | (wdat & wbits);
      if (addr == 2'd1)
        oe_q  <= (oe_q & ~wbits) | (wdat & wbits);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_w = sync_q[SYNC_STAGES-1];

`ifdef RV32_GPIO_IRQ_EN
  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;

  assign rise = in_w & ~hist_q;
  assign clr  = (wr && addr == 2'd3) ? (wdat & wbits) : '0;

  // A new edge overrides a same-cycle W1C of that bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      stat_q <= '0;
    end else begin
      hist_q <= in_w;
      stat_q <= (stat_q & ~clr) | rise;
    end
  end

  assign stat_w  = stat_q;
  assign irq_out = |stat_q;
`else
  assign stat_w  = '0;
  assign irq_out = 1'b0;
`endif

  always_comb begin
    rmux = '0;
    unique case (1'b1)
      addr == 2'd0: rmux[WIDTH-1:0] = out_q;
      addr == 2'd1: rmux[WIDTH-1:0] = oe_q;
      addr == 2'd2: rmux[WIDTH-1:0] = in_w;
      addr == 2'd3: rmux[WIDTH-1:0] = stat_w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      rdata_q <= '0;
    else
      rdata_q <= rd ? rmux : 32'h0;
  end

  assign bus.read_value_out = rdata_q;
  assign gpio_out           = out_q;
  assign gpio_oe_out        = oe_q;

endmodule

// File: tb/tb_rv32_gpio.sv
// Directed bench for rv32_gpio (WIDTH=8, SYNC_STAGES=2);
// interrupt steps apply when RV32_GPIO_IRQ_EN is defined.
module tb_rv32_gpio;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe_out;
  logic       irq_out;
  int         tests = 0;
  int         fails = 0;

  rv32_gpio_if bus ();

  rv32_gpio #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe_out (gpio_oe_out),
    .irq_out     (irq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sel_in         = 1'b0;
    bus.read_en_in     = 1'b0;
    bus.write_mask_in  = 4'h0;
    bus.address_in     = 32'h0;
    bus.write_value_in = 32'h0;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d,
                    input logic [3:0] m);
    bus.sel_in         = 1'b1;
    bus.read_en_in     = 1'b0;
    bus.write_mask_in  = m;
    bus.address_in     = {28'h0, a, 2'b00};
    bus.write_value_in = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [1:0] a,
                    input logic [31:0] exp,
                    input string tag);
    bus.sel_in         = 1'b1;
    bus.read_en_in     = 1'b1;
    bus.write_mask_in  = 4'h0;
    bus.address_in     = {28'h0, a, 2'b00};
    bus.write_value_in = 32'h0;
    tick();
    idle();
    check(tag, bus.read_value_out, exp);
  endtask

  initial begin
    idle();
    gpio_in = 8'h00;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out", {24'h0, gpio_out}, 32'h0);
    check("rst_oe", {24'h0, gpio_oe_out}, 32'h0);
    check("rst_irq", {31'h0, irq_out}, 32'h0);
    check("rst_rdata", bus.read_value_out, 32'h0);

    wr(2'd0, 32'h0000_00A5, 4'hF);
    check("out_a5", {24'h0, gpio_out}, 32'hA5);
    rd(2'd0, 32'h0000_00A5, "rd_out_a5");
    tick();
    check("rdata_idle", bus.read_value_out, 32'h0);

    wr(2'd0, 32'h0000_00FF, 4'hF);
    wr(2'd0, 32'h0000_1234, 4'b0010);
    check("lane1_drop", {24'h0, gpio_out}, 32'hFF);
    rd(2'd0, 32'h0000_00FF, "rd_out_ff");

    wr(2'd0, 32'hFFFF_FF3C, 4'b0001);
    check("lane0_only", {24'h0, gpio_out}, 32'h3C);
    rd(2'd0, 32'h0000_003C, "rd_out_3c");

    wr(2'd1, 32'h0000_005A, 4'hF);
    check("oe_5a", {24'h0, gpio_oe_out}, 32'h5A);
    rd(2'd1, 32'h0000_005A, "rd_oe_5a");

    bus.sel_in         = 1'b0;
    bus.read_en_in     = 1'b1;
    bus.write_mask_in  = 4'hF;
    bus.address_in     = 32'h0;
    bus.write_value_in = 32'h0;
    tick();
    idle();
    check("nosel_out", {24'h0, gpio_out}, 32'h3C);
    check("nosel_rd", bus.read_value_out, 32'h0);

    wr(2'd2, 32'h0000_00FF, 4'hF);
    rd(2'd2, 32'h0, "in_ro");

    bus.sel_in         = 1'b1;
    bus.read_en_in     = 1'b1;
    bus.write_mask_in  = 4'hF;
    bus.address_in     = 32'h0;
    bus.write_value_in = 32'h11;
    tick();
    idle();
    check("rw_pre", bus.read_value_out, 32'h3C);
    check("rw_out", {24'h0, gpio_out}, 32'h11);

    gpio_in = 8'h81;
    rd(2'd2, 32'h0, "in_k");
    rd(2'd2, 32'h0, "in_k1");
    rd(2'd2, 32'h81, "in_k2");

`ifdef RV32_GPIO_IRQ_EN
    check("irq_81", {31'h0, irq_out}, 32'h1);
    rd(2'd3, 32'h81, "st_81");
    wr(2'd3, 32'hFF, 4'hF);
    check("irq_clr", {31'h0, irq_out}, 32'h0);
    rd(2'd3, 32'h0, "st_clr");

    gpio_in = 8'h89;
    tick();
    check("irq3_k", {31'h0, irq_out}, 32'h0);
    tick();
    check("irq3_k1", {31'h0, irq_out}, 32'h0);
    tick();
    check("irq3_k2", {31'h0, irq_out}, 32'h1);
    rd(2'd3, 32'h08, "st_08");
    wr(2'd3, 32'h08, 4'h1);
    check("irq3_w1c", {31'h0, irq_out}, 32'h0);

    gpio_in = 8'h88;
    repeat (4) tick();
    gpio_in = 8'h89;
    tick();
    tick();
    wr(2'd3, 32'h01, 4'h1);
    check("set_wins", {31'h0, irq_out}, 32'h1);
    rd(2'd3, 32'h01, "st_01");
`else
    check("noirq", {31'h0, irq_out}, 32'h0);
    rd(2'd3, 32'h0, "st_zero");
    wr(2'd3, 32'hFF, 4'hF);
    rd(2'd3, 32'h0, "st_wr_ign");
    gpio_in = 8'h89;
    repeat (4) tick();
`endif

    wr(2'd0, 32'hFF, 4'hF);
    reset              = 1'b1;
    bus.sel_in         = 1'b1;
    bus.read_en_in     = 1'b1;
    bus.write_mask_in  = 4'hF;
    bus.address_in     = 32'h0;
    bus.write_value_in = 32'h0F;
    tick();
    reset = 1'b0;
    idle();
    check("mid_out", {24'h0, gpio_out}, 32'h0);
    check("mid_oe", {24'h0, gpio_oe_out}, 32'h0);
    check("mid_irq", {31'h0, irq_out}, 32'h0);
    check("mid_rdata", bus.read_value_out, 32'h0);
    rd(2'd0, 32'h0, "mid_wr_drop");
    check("refill_r1", {31'h0, irq_out}, 32'h0);
    rd(2'd1, 32'h0, "mid_oe_rd");
    check("refill_r2", {31'h0, irq_out}, 32'h0);
    tick();
`ifdef RV32_GPIO_IRQ_EN
    check("refill_r3", {31'h0, irq_out}, 32'h1);
    rd(2'd3, 32'h89, "st_refill");
`else
    check("refill_r3", {31'h0, irq_out}, 32'h0);
    rd(2'd2, 32'h89, "in_refill");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
